// File: rtl/flit_packetizer.sv
// Purpose : turns a packet request plus a stream of SRAM words into a
//           head/body/tail flit sequence for the router injection FIFO.
// Latency : head written 1 cycle after request accept; one flit per cycle.
// Backpr. : fifo_full stalls every state; body words also wait on data_valid.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   pkt_valid / pkt_ready    packet request handshake (ready only in IDLE)
//   src_addr, dest_addr,     request fields, sampled when the request is
//   body_len                 accepted (body_len clamped to MAX_BODY)
//   data_in / data_valid /   SRAM word stream; data_ready marks the cycle a
//   data_ready               word is consumed into a body flit
//   fifo_full                downstream FIFO cannot take a write this cycle
//   flit_out, write_enable   flit {type[1:0], payload}; FIFO write strobe
//   pkt_count                packets whose tail has been written (wraps)
module flit_packetizer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int MAX_BODY = 15,
  localparam int LEN_W   = $clog2(MAX_BODY + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  body_len,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              fifo_full,
  output logic [DATA_W+1:0] flit_out,
  output logic              write_enable,
  output logic [15:0]       pkt_count
);

  localparam int HDR_W = 2 * ADDR_W + LEN_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEAD = 2'd1;
  localparam logic [1:0] BODY = 2'd2;
  localparam logic [1:0] TAIL = 2'd3;

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_BODY = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  // The head payload must hold {len, src, dest}.
  generate
    if (HDR_W > DATA_W) begin : g_width_check
      $error("flit_packetizer: 2*ADDR_W + LEN_W exceeds DATA_W");
    end
  endgenerate

  logic [1:0]        state;
  logic [ADDR_W-1:0] lat_src;
  logic [ADDR_W-1:0] lat_dest;
  logic [LEN_W-1:0]  lat_len;
  logic [LEN_W-1:0]  body_cnt;
  logic [DATA_W-1:0] checksum;
  logic [15:0]       count;

  logic [LEN_W-1:0]  len_clamp;
  logic [DATA_W-1:0] head_payload;
  logic              head_wr;
  logic              body_wr;
  logic              tail_wr;

  // Clamping is only needed when LEN_W can encode values above MAX_BODY;
  // otherwise the comparison would be constant.
  generate
    if ((1 << LEN_W) - 1 > MAX_BODY) begin : g_clamp
      assign len_clamp = (body_len > LEN_W'(MAX_BODY)) ? LEN_W'(MAX_BODY) : body_len;
    end else begin : g_no_clamp
      assign len_clamp = body_len;
    end
  endgenerate

  // Head payload: zero-padded {len, src, dest}, dest in the LSBs.
  always_comb begin
    head_payload = '0;
    head_payload[HDR_W-1:0] = {lat_len, lat_src, lat_dest};
  end

  assign head_wr = (state == HEAD) && !fifo_full;
  assign body_wr = (state == BODY) && data_valid && !fifo_full;
  assign tail_wr = (state == TAIL) && !fifo_full;

  assign pkt_ready    = (state == IDLE);
  assign data_ready   = body_wr;
  assign write_enable = head_wr || body_wr || tail_wr;
  assign pkt_count    = count;

  // Flit is presented for the whole state (stable across stalls); zero in IDLE.
  always_comb begin
    flit_out = '0;
    case (state)
      HEAD:    flit_out = {TYPE_HEAD, head_payload};
      BODY:    flit_out = {TYPE_BODY, data_in};
      TAIL:    flit_out = {TYPE_TAIL, checksum};
      default: flit_out = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat_src  <= '0;
      lat_dest <= '0;
      lat_len  <= '0;
      body_cnt <= '0;
      checksum <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_valid) begin
            lat_src  <= src_addr;
            lat_dest <= dest_addr;
            lat_len  <= len_clamp;
            checksum <= '0;
            body_cnt <= '0;
            state    <= HEAD;
          end
        end
        HEAD: begin
          if (head_wr) begin
            state <= (lat_len != '0) ? BODY : TAIL;
          end
        end
        BODY: begin
          if (body_wr) begin
            checksum <= checksum ^ data_in;
            body_cnt <= body_cnt + LEN_W'(1);
            // Last body word: counter still holds the index of this word.
            if (body_cnt == lat_len - LEN_W'(1)) begin
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          if (tail_wr) begin
            count <= count + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
